// File: rtl/ps2_pkg.sv
// Shared PS/2 types and helpers for the host-side transmitter (and the receiver when it is revised).
package ps2_pkg;

    localparam int unsigned PS2_FILTER_W = 8;
    localparam int unsigned PS2_DATA_W   = 8;
    localparam int unsigned PS2_FRAME_W  = PS2_DATA_W + 1;
    localparam int unsigned PS2_BIT_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP,
        ACK
    } ps2tx_state_t;

    function automatic logic odd_parity(input logic [PS2_DATA_W-1:0] d);
        return ~^d;
    endfunction

    // States in which the device owns the clock and the frame is in flight.
    function automatic logic in_frame(input ps2tx_state_t s);
        return (s == START) || (s == DATA) || (s == STOP) || (s == ACK);
    endfunction

endpackage

// File: rtl/ps2tx_if.sv
// Host-side PS/2 transmitter bus: write request, raw pin levels in, pull-low enables and status out.
interface ps2tx_if;

    logic                             wr_ps2;
    logic [ps2_pkg::PS2_DATA_W-1:0]   din;
    logic                             ps2c_in;
    logic                             ps2d_in;
    logic                             ps2c_oe;
    logic                             ps2d_oe;
    logic                             tx_idle;
    logic                             tx_done_tick;
    logic                             tx_ack_err;
    logic                             tx_err_tick;

    modport master (
        output wr_ps2, din, ps2c_in, ps2d_in,
        input  ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_ack_err, tx_err_tick
    );

    modport slave (
        input  wr_ps2, din, ps2c_in, ps2d_in,
        output ps2c_oe, ps2d_oe, tx_idle, tx_done_tick, tx_ack_err, tx_err_tick
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// Glitch filter on the raw PS/2 clock: level changes only after 8 identical samples; flags falling edges.
module ps2_clk_filter
    import ps2_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic ps2c_in,
    output logic f_ps2c,
    output logic f_next_c,
    output logic fall_c
);

    logic [PS2_FILTER_W-1:0] filter;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filter <= '0;
            f_ps2c <= 1'b0;
        end else begin
            filter <= {ps2c_in, filter[PS2_FILTER_W-1:1]};
            f_ps2c <= f_next_c;
        end
    end

    always_comb begin
        f_next_c = f_ps2c;
        if (&filter) begin
            f_next_c = 1'b1;
        end else if (~|filter) begin
            f_next_c = 1'b0;
        end
        fall_c = f_ps2c & ~f_next_c;
    end

endmodule

// File: rtl/ps2tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 8 data + odd parity + stop, then device ack check.
// Optional device-clock watchdog enabled by defining PS2TX_TIMEOUT_EN.
module ps2tx
    import ps2_pkg::*;
#(
    parameter int unsigned RTS_CYCLES     = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic     clk,
    input  logic     reset_n,
    ps2tx_if.slave   bus
);

    localparam int unsigned RTS_W = $clog2(RTS_CYCLES + 1);

    ps2tx_state_t             state, state_next;
    logic [PS2_FRAME_W-1:0]   b_reg, b_next;
    logic [RTS_W-1:0]         rts_cnt, rts_next;
    logic [PS2_BIT_W-1:0]     n_reg, n_next;
    logic                     ack_r, ack_next;

    logic                     f_ps2c, f_next, fall;
    logic                     timeout;
    logic                     err_next;

    logic                     ps2c_oe_r, ps2d_oe_r, tx_idle_r;
    logic                     done_r, ack_err_r, err_r;
    logic                     ps2c_oe_d, ps2d_oe_d, tx_idle_d, done_d, ack_err_d;

    ps2_clk_filter u_filter (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2c_in  (bus.ps2c_in),
        .f_ps2c   (f_ps2c),
        .f_next_c (f_next),
        .fall_c   (fall)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            b_reg   <= '0;
            rts_cnt <= '0;
            n_reg   <= '0;
            ack_r   <= 1'b0;
        end else begin
            state   <= state_next;
            b_reg   <= b_next;
            rts_cnt <= rts_next;
            n_reg   <= n_next;
            ack_r   <= ack_next;
        end
    end

    // Next state; the device clock is ignored in RTS because the host is driving it low.
    always_comb begin
        state_next = state;
        b_next     = b_reg;
        rts_next   = rts_cnt;
        n_next     = n_reg;
        ack_next   = ack_r;
        unique case (state)
            IDLE: begin
                if (bus.wr_ps2) begin
                    b_next     = {odd_parity(bus.din), bus.din};
                    rts_next   = RTS_W'(RTS_CYCLES - 1);
                    state_next = RTS;
                end
            end
            RTS: begin
                if (rts_cnt == '0) begin
                    state_next = START;
                end else begin
                    rts_next = rts_cnt - RTS_W'(1);
                end
            end
            START: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (fall) begin
                    n_next     = PS2_BIT_W'(8);
                    state_next = DATA;
                end
            end
            DATA: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (fall) begin
                    b_next = {1'b0, b_reg[PS2_FRAME_W-1:1]};
                    if (n_reg == '0) begin
                        state_next = STOP;
                    end else begin
                        n_next = n_reg - PS2_BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (timeout) begin
                    state_next = IDLE;
                end else if (fall) begin
                    ack_next   = bus.ps2d_in;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (f_ps2c || timeout) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are computed from next-cycle state so each one lines up with its state.
    always_comb begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        tx_idle_d = 1'b0;
        done_d    = 1'b0;
        ack_err_d = 1'b0;
        ps2c_oe_d = (state_next == RTS);
        ps2d_oe_d = (state_next == START) || ((state_next == DATA) && !b_next[0]);
        tx_idle_d = (state_next == IDLE);
        done_d    = (state_next == ACK) && f_next;
        ack_err_d = done_d && ack_next;
    end

`ifdef PS2TX_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt, wd_next;

    // A completing ACK has priority over an expiring watchdog in the same cycle.
    assign timeout = in_frame(state) && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1))
                     && !((state == ACK) && f_ps2c);

    always_comb begin
        wd_next = wd_cnt + WD_W'(1);
        if (!in_frame(state_next)) begin
            wd_next = '0;
        end else if ((state_next == START) && (state != START)) begin
            wd_next = '0;
        end else if (fall) begin
            wd_next = '0;
        end
        err_next = in_frame(state_next) && (wd_next == WD_W'(TIMEOUT_CYCLES - 1))
                   && !((state_next == ACK) && f_next);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_next;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign err_next   = 1'b0;
`endif

    // Output registers; reset releases both lines immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2c_oe_r <= 1'b0;
            ps2d_oe_r <= 1'b0;
            tx_idle_r <= 1'b1;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            ps2c_oe_r <= ps2c_oe_d;
            ps2d_oe_r <= ps2d_oe_d;
            tx_idle_r <= tx_idle_d;
            done_r    <= done_d;
            ack_err_r <= ack_err_d;
            err_r     <= err_next;
        end
    end

    assign bus.ps2c_oe      = ps2c_oe_r;
    assign bus.ps2d_oe      = ps2d_oe_r;
    assign bus.tx_idle      = tx_idle_r;
    assign bus.tx_done_tick = done_r;
    assign bus.tx_ack_err   = ack_err_r;
    assign bus.tx_err_tick  = err_r;

endmodule
